// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Divide-by-zero completes immediately with q = all ones, r = x and dbz set.
module div_seq #(
   parameter int bw = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [bw-1:0] x,
   input  logic [bw-1:0] y,
   output logic          busy,
   output logic          done,
   output logic [bw-1:0] q,
   output logic [bw-1:0] r,
   output logic          dbz
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int            CW   = (bw > 1) ? $clog2(bw) : 1;
   localparam logic [CW-1:0] LAST = CW'(bw - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [bw-1:0] dvd_q,   dvd_d;
   logic [bw-1:0] dvs_q,   dvs_d;
   logic [bw:0]   rem_q,   rem_d;
   logic [bw-1:0] q_q,     q_d;
   logic [bw-1:0] r_q,     r_d;
   logic          dbz_q,   dbz_d;

   logic [bw:0]   t;
   logic          qbit;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;

      t    = {rem_q[bw-1:0], dvd_q[bw-1]};
      qbit = (t >= {1'b0, dvs_q});

      case (state_q)
         IDLE: begin
            if (start) begin
               if (y != '0) begin
                  state_d = RUN;
                  dvd_d   = x;
                  dvs_d   = y;
                  rem_d   = '0;
                  cnt_d   = '0;
               end else begin
                  state_d = DONE;
                  q_d     = '1;
                  r_d     = x;
                  dbz_d   = 1'b1;
               end
            end
         end
         RUN: begin
            // Dividend bits shift out the top while quotient bits fill in from the bottom.
            rem_d = qbit ? (t - {1'b0, dvs_q}) : t;
            dvd_d = {dvd_q[bw-2:0], qbit};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
               q_d     = dvd_d;
               r_d     = rem_d[bw-1:0];
               dbz_d   = 1'b0;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign q    = q_q;
   assign r    = r_q;
   assign dbz  = dbz_q;

endmodule
